exe_mdu_stage: RTL and testbench
================================

Name: exe_mdu_stage

Overview:
- Parametrised execute-stage multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the 5-stage pipeline.
- Sits in EX beside the ALU and reuses the same 2-bit operand-forwarding scheme (01 = MEM ALU result, 10 = WB data).
- Operations are iterative and multi-cycle, so the block adds a stall handshake toward the hazard unit that the single-cycle ALU path never needed.

Parameters:
- XLEN, 32: operand/result width. Legal values are 32 and 64.
- CNT_W, $clog2(XLEN)+1: iteration counter width. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  EX holds an M-extension instruction (opcode OP, funct7 = 0000001).
- flush  in  1  squash the current operation (branch taken or trap).
- funct3  in  3  M-op select: 000 MUL … 111 REMU.
- rs1_data  in  XLEN  register-file operand A.
- rs2_data  in  XLEN  register-file operand B.
- forward_rs1  in  2  forwarding select for A: 00 regfile, 01 MEM, 10 WB.
- forward_rs2  in  2  forwarding select for B: same encoding.
- alu_result_MEM  in  XLEN  MEM-stage forward value.
- wb_data_WB  in  XLEN  WB-stage forward value.
- stall_out  out  1  freeze IF/ID/EX and insert a bubble into MEM.
- result  out  XLEN  M-op result, meaningful only while result_valid is high.
- result_valid  out  1  single-cycle completion strobe.

Behaviour:
- Reset: state IDLE. stall_out, result_valid and result are 0. Counter and internal registers are cleared.
- Operand capture: forwarding muxes are combinational. Forwarded operands are latched on the start cycle only. Later changes to the forward inputs are ignored.
- States: IDLE, MUL, DIV, DONE.
- IDLE → MUL: valid_in high and funct3[2] = 0.
- IDLE → DIV: valid_in high and funct3[2] = 1 and no special case applies.
- IDLE → DONE, fast path: divisor = 0, giving quotient all-ones and remainder = dividend. Signed overflow (DIV/REM of −2^(XLEN−1) by −1), giving quotient = −2^(XLEN−1) and remainder = 0.
- MUL: radix-2 shift-add on operand magnitudes into a 2·XLEN accumulator. Exactly XLEN iterations, then DONE.
- DIV: restoring division on magnitudes. Exactly XLEN iterations, then DONE.
- DONE: result_valid = 1 for one cycle, then IDLE. The block does not restart on the same valid_in during DONE.
- Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats A as signed and B as unsigned. MULHU/DIVU/REMU are unsigned.
- Sign fix-up: product sign = signA XOR signB. Quotient sign = signA XOR signB. Remainder sign = signA.
- Result select: MUL returns the low XLEN bits of the product. The MULH* ops return the high XLEN bits.
- stall_out = (valid_in & state==IDLE) | state==MUL | state==DIV. It is therefore low in DONE, so the pipeline advances on the DONE cycle.
- Latency: MUL and normal DIV take XLEN+2 cycles, counted from the valid_in cycle to the cycle after DONE. Fast-path cases take 2 cycles.
- flush: has priority over everything except rst. State goes to IDLE next cycle, no result_valid is produced, and stall_out is forced to 0 in the flush cycle.
- Simultaneous flush and valid_in in IDLE: flush wins and no operation starts.
- rst mid-operation: same as flush, and all registers are cleared.
- Counter: no wrap-around hazard. It is compared with XLEN−1 and cleared on entry to MUL or DIV.

Decomposition:
- Shared constants header, alongside the existing control-encoding defines:
  - FUNCT7_MULDIV
  - FUNCT3 codes for all eight M ops
  - FWD_NONE, FWD_MEM, FWD_WB
  - MDU state encodings
- Sub-module mdu_iter_core holds the MUL and DIV datapaths: accumulator, shifter, counter.
- The top level keeps forwarding, sign handling, the FSM and result select.

Test Plan:
- MUL 7 × −3, XLEN=32 → result 0xFFFFFFEB. result_valid pulses at cycle 33. stall_out is high for cycles 0–32.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU −1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF, and REM 5 / 0 → 5, each in 2 cycles. DIV 0x80000000 / −1 → 0x80000000, and REM of the same → 0.
- forward_rs1 = 01 with alu_result_MEM = 12, then MEM changes on the next cycle; DIVU by 4 → result 3, proving operands are latched at start.
- flush at iteration 10 of a DIV → no result_valid, stall_out = 0, state IDLE. A new MUL 2 × 3 issued next cycle → 6. Repeat with rst mid-MUL → all outputs 0.

Source files
------------

// File: rtl/exe_mdu_stage_pkg.sv
// Shared M-extension encodings: funct7/funct3 codes, forwarding selects,
// MDU state encoding and operand-signedness helpers.
package exe_mdu_stage_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  // Operand A is signed for every op except the fully unsigned ones.
  function automatic logic op_a_signed(input logic [2:0] f3);
    case (f3)
      F3_MULHU, F3_DIVU, F3_REMU: return 1'b0;
      default:                    return 1'b1;
    endcase
  endfunction

  // Operand B is signed only for MUL/MULH/DIV/REM (MULHSU keeps B unsigned).
  function automatic logic op_b_signed(input logic [2:0] f3);
    case (f3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exe_mdu_stage_iter.sv
// Iterative magnitude datapath: radix-2 shift-add multiply and restoring
// divide sharing one 2*XLEN accumulator, plus the iteration counter.
// Multiply: acc = {partial_hi, multiplier}; divide: acc = {remainder, dividend/quotient}.
module mdu_iter_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              is_div_i,
  input  logic              step_i,
  input  logic [XLEN-1:0]   a_mag_i,
  input  logic [XLEN-1:0]   b_mag_i,
  output logic              last_o,
  output logic [2*XLEN-1:0] acc_step_o
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   mcand_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_div_q;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] div_next;

  // One iteration of either algorithm, evaluated from the current accumulator.
  always_comb begin
    mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next   = {mul_sum, acc_q[XLEN-1:1]};
    div_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff   = div_shift - {1'b0, mcand_q};
    div_next   = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    acc_step_o = is_div_q ? div_next : mul_next;
    last_o     = (cnt_q == CNT_W'(XLEN - 1));
  end

  // Load operands on start, then advance one iteration per step cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else if (load_i) begin
      acc_q    <= {{XLEN{1'b0}}, (is_div_i ? a_mag_i : b_mag_i)};
      mcand_q  <= is_div_i ? b_mag_i : a_mag_i;
      cnt_q    <= '0;
      is_div_q <= is_div_i;
    end else if (step_i) begin
      acc_q    <= acc_step_o;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/exe_mdu_stage.sv
// Execute-stage RV32M/RV64M multiply/divide unit: operand forwarding,
// sign handling, divide special cases, control FSM and result select.
module exe_mdu_stage
  import exe_mdu_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [1:0]      forward_rs1,
  input  logic [1:0]      forward_rs2,
  input  logic [XLEN-1:0] alu_result_MEM,
  input  logic [XLEN-1:0] wb_data_WB,
  output logic            stall_out,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  mdu_state_e        state_q;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   result_q;
  logic              result_valid_q;

  logic [XLEN-1:0]   op_a, op_b, a_mag, b_mag;
  logic              sign_a, sign_b, div_zero, div_ovf, fast_path, neg_d;
  logic [XLEN-1:0]   fast_result, final_result;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic              core_last, core_load, core_step, is_idle, busy;

  // Forwarding muxes, magnitudes, special-case detection and result fix-up.
  always_comb begin
    case (forward_rs1)
      FWD_MEM: op_a = alu_result_MEM;
      FWD_WB:  op_a = wb_data_WB;
      default: op_a = rs1_data;
    endcase
    case (forward_rs2)
      FWD_MEM: op_b = alu_result_MEM;
      FWD_WB:  op_b = wb_data_WB;
      default: op_b = rs2_data;
    endcase
    sign_a    = op_a_signed(funct3) & op_a[XLEN-1];
    sign_b    = op_b_signed(funct3) & op_b[XLEN-1];
    a_mag     = sign_a ? -op_a : op_a;
    b_mag     = sign_b ? -op_b : op_b;
    // Remainder takes the dividend's sign; product and quotient take signA^signB.
    neg_d     = (funct3[2] & funct3[1]) ? sign_a : (sign_a ^ sign_b);
    div_zero  = (op_b == '0);
    div_ovf   = ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
    fast_path = funct3[2] & (div_zero | div_ovf);
    if (!funct3[1]) fast_result = div_zero ? '1 : op_a;
    else            fast_result = div_zero ? op_a : '0;

    prod_fix = neg_q ? -acc_step : acc_step;
    if (!op_q[2])     final_result = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                          : prod_fix[2*XLEN-1:XLEN];
    else if (op_q[1]) final_result = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    else              final_result = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];

    is_idle   = (state_q == MDU_IDLE);
    busy      = (state_q == MDU_MUL) | (state_q == MDU_DIV);
    core_load = is_idle & valid_in & ~flush;
    core_step = busy & ~flush;
    stall_out = ~(flush | rst) & ((valid_in & is_idle) | busy);
  end

  mdu_iter_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (core_load),
    .is_div_i  (funct3[2]),
    .step_i    (core_step),
    .a_mag_i   (a_mag),
    .b_mag_i   (b_mag),
    .last_o    (core_last),
    .acc_step_o(acc_step)
  );

  // Control FSM; result and strobe are registered and held only in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= MDU_IDLE;
      op_q           <= '0;
      neg_q          <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
      if (flush) begin
        state_q <= MDU_IDLE;
      end else begin
        case (state_q)
          MDU_IDLE: if (valid_in) begin
            op_q  <= funct3;
            neg_q <= neg_d;
            if (!funct3[2]) begin
              state_q <= MDU_MUL;
            end else if (fast_path) begin
              state_q        <= MDU_DONE;
              result_q       <= fast_result;
              result_valid_q <= 1'b1;
            end else begin
              state_q <= MDU_DIV;
            end
          end
          MDU_MUL, MDU_DIV: if (core_last) begin
            state_q        <= MDU_DONE;
            result_q       <= final_result;
            result_valid_q <= 1'b1;
          end
          default: state_q <= MDU_IDLE;
        endcase
      end
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_exe_mdu_stage.sv
// Directed self-checking bench for exe_mdu_stage (XLEN = 32).
module tb_exe_mdu_stage;
  import exe_mdu_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, valid_in, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, alu_result_MEM, wb_data_WB;
  logic [1:0]  forward_rs1, forward_rs2;
  logic        stall_out, result_valid;
  logic [31:0] result;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  exe_mdu_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
    .alu_result_MEM(alu_result_MEM), .wb_data_WB(wb_data_WB),
    .stall_out(stall_out), .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Called just after a negedge with the op already driven at cycle cyc0.
  task automatic wait_result(input int cyc0, output logic [31:0] res, output int lat,
                             output logic stall_ok, output logic done_stall,
                             output logic timed_out);
    int cyc;
    cyc        = cyc0;
    stall_ok   = 1'b1;
    timed_out  = 1'b1;
    res        = '0;
    done_stall = 1'b0;
    #1;
    stall_ok = stall_out;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      cyc++;
      #1;
      if (result_valid) begin
        res        = result;
        done_stall = stall_out;
        timed_out  = 1'b0;
        break;
      end
      stall_ok = stall_ok & stall_out;
    end
    lat = cyc;
  endtask

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int          lat;
    logic        s_ok, d_st, to;
    @(negedge clk);
    funct3 = f3; rs1_data = a; rs2_data = b;
    forward_rs1 = FWD_NONE; forward_rs2 = FWD_NONE;
    valid_in = 1'b1;
    wait_result(0, res, lat, s_ok, d_st, to);
    chk({nm, " timeout"}, {31'd0, to}, 32'd0);
    chk({nm, " result"}, res, exp);
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " stall while busy"}, {31'd0, s_ok}, 32'd1);
    chk({nm, " stall in DONE"}, {31'd0, d_st}, 32'd0);
    valid_in = 1'b0;
    @(negedge clk); #1;
    chk({nm, " strobe one cycle"}, {31'd0, result_valid}, 32'd0);
    $display("%s f3=%b a=%h b=%h -> result=%h lat=%0d", nm, f3, a, b, res, lat);
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    logic        s_ok, d_st, to;

    vecs[0]  = '{F3_MUL,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{F3_MULH,   32'h80000000,  32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{F3_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{F3_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{F3_MUL,    32'h12345678,  32'd9,        32'hA3D70A38, 33};
    vecs[5]  = '{F3_MULH,   32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 33};
    vecs[6]  = '{F3_DIV,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 33};
    vecs[7]  = '{F3_REM,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 33};
    vecs[8]  = '{F3_DIVU,   32'd100,       32'd7,        32'd14,       33};
    vecs[9]  = '{F3_REMU,   32'd100,       32'd7,        32'd2,        33};
    vecs[10] = '{F3_DIV,    32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[11] = '{F3_REM,    32'd7,         32'hFFFFFFFE, 32'd1,        33};
    vecs[12] = '{F3_DIV,    32'd5,         32'd0,        32'hFFFFFFFF, 1};
    vecs[13] = '{F3_REM,    32'd5,         32'd0,        32'd5,        1};
    vecs[14] = '{F3_DIV,    32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
    vecs[15] = '{F3_REM,    32'h80000000,  32'hFFFFFFFF, 32'd0,        1};
    vecs[16] = '{F3_DIVU,   32'h80000000,  32'hFFFFFFFF, 32'd0,        33};
    vecs[17] = '{F3_REMU,   32'd5,         32'd0,        32'd5,        1};
    vecs[18] = '{F3_MULHU,  32'h80000000,  32'd2,        32'd1,        33};

    rst = 1'b1; valid_in = 1'b0; flush = 1'b0; funct3 = '0;
    rs1_data = '0; rs2_data = '0; alu_result_MEM = '0; wb_data_WB = '0;
    forward_rs1 = FWD_NONE; forward_rs2 = FWD_NONE;
    repeat (3) @(negedge clk);
    #1;
    chk("reset result", result, 32'd0);
    chk("reset result_valid", {31'd0, result_valid}, 32'd0);
    chk("reset stall_out", {31'd0, stall_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Forwarded operand is captured on the start cycle only.
    @(negedge clk);
    funct3 = F3_DIVU; rs1_data = 32'd999; rs2_data = 32'd4;
    forward_rs1 = FWD_MEM; alu_result_MEM = 32'd12; valid_in = 1'b1;
    @(negedge clk);
    alu_result_MEM = 32'd100; wb_data_WB = 32'd77; forward_rs1 = FWD_WB;
    wait_result(1, res, lat, s_ok, d_st, to);
    chk("fwd timeout", {31'd0, to}, 32'd0);
    chk("fwd latched result", res, 32'd3);
    valid_in = 1'b0; forward_rs1 = FWD_NONE;
    $display("fwd DIVU MEM=12 / 4 -> result=%h lat=%0d", res, lat);

    // Flush at iteration 10 of a DIV, then a fresh MUL.
    @(negedge clk);
    funct3 = F3_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; valid_in = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1; #1;
    chk("flush stall forced low", {31'd0, stall_out}, 32'd0);
    @(negedge clk);
    flush = 1'b0; valid_in = 1'b0; #1;
    chk("flush no result_valid", {31'd0, result_valid}, 32'd0);
    chk("flush back to idle", {31'd0, stall_out}, 32'd0);
    $display("flush DIV at iteration 10 -> stall=%b result_valid=%b", stall_out, result_valid);
    run_op("post-flush MUL", F3_MUL, 32'd2, 32'd3, 32'd6, 33);

    // Flush and valid_in together in IDLE: nothing starts.
    @(negedge clk);
    funct3 = F3_MUL; rs1_data = 32'd4; rs2_data = 32'd4; valid_in = 1'b1; flush = 1'b1; #1;
    chk("flush+valid stall", {31'd0, stall_out}, 32'd0);
    @(negedge clk);
    valid_in = 1'b0; flush = 1'b0; #1;
    chk("flush+valid no start", {31'd0, stall_out}, 32'd0);
    $display("flush with valid_in in IDLE -> stall=%b", stall_out);

    // Reset in the middle of a MUL.
    @(negedge clk);
    funct3 = F3_MUL; rs1_data = 32'd5; rs2_data = 32'd5; valid_in = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst mid-MUL result", result, 32'd0);
    chk("rst mid-MUL result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst mid-MUL stall", {31'd0, stall_out}, 32'd0);
    rst = 1'b0; valid_in = 1'b0;
    @(negedge clk); #1;
    chk("rst mid-MUL idle after", {31'd0, stall_out}, 32'd0);
    $display("rst mid-MUL -> result=%h result_valid=%b stall=%b", result, result_valid, stall_out);
    run_op("post-rst MUL", F3_MUL, 32'd5, 32'd5, 32'd25, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
